// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned BTN_NEXT = 0;
  localparam int unsigned BTN_PRE  = 1;
  localparam int unsigned BTN_AUTO = 2;

  // Defaults for a 100 MHz sysclk
  localparam int unsigned DEF_NUM_BTN         = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and press/release pulses.
// Defining BTN_AUTOREPEAT_EN adds a hold-to-repeat counter (per-instance REPEAT_EN).
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rls
);

  localparam int unsigned      CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the first stable sample is accepted directly
  localparam bit               ACCEPT_NOW = (DEBOUNCE_CYCLES <= 1);

  logic             sync1_q;
  logic             s_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             rls_q, rls_d;

  // Two-flop synchroniser; the FSM only ever sees s_q
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_fire_c;

  // Repeat timer runs only while stably held; any other state parks it at zero
  always_comb begin
    rep_d       = '0;
    rep_first_d = 1'b1;
    rep_fire_c  = 1'b0;
    if (REPEAT_EN && (state_q == HELD) && s_q) begin
      rep_first_d = rep_first_q;
      if (rep_q == REP_W'(rep_first_q ? (REPEAT_DELAY - 1) : (REPEAT_PERIOD - 1))) begin
        rep_fire_c  = 1'b1;
        rep_first_d = 1'b0;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    rls_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          if (ACCEPT_NOW) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s_q) begin
          if (ACCEPT_NOW) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            rls_d   = 1'b1;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_fire_c) begin
          pulse_d = 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rls_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rls_q   <= rls_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign rls   = rls_q;

endmodule

// File: rtl/btn_conditioner.sv
// Synchronises and debounces the Next/Pre/Auto buttons into clean levels and pulses.
// Define BTN_AUTOREPEAT_EN for hold-to-repeat on every channel except Auto.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_release
);

  // Channels are fully independent; priority between them is resolved downstream
  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_EN      (i != int'(BTN_AUTO)),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .pulse (btn_pulse[i]),
      .rls   (btn_release[i])
    );
  end

endmodule
